accum_table_system: RTL and testbench
=====================================

// Module: accum_table_system
// PURPOSE
// - Output accumulator for the systolic-array matmul unit. It holds partial sums for a MAX_OUT_ROWS x MAX_OUT_COLS result tile.
// - Contains three parts: a banked accumulator table with one bank per array column, a write controller and a read controller.
// - Write-side timing is skewed per column to match the systolic array's diagonal output wavefront.
// - The read side returns one full result row (all columns) per access.
// PARAMETERS
// DATA_WIDTH    8    bits per accumulator entry / per column datum
// MAX_OUT_ROWS  128  max rows of the output matrix
// MAX_OUT_COLS  128  max cols of the output matrix
// SYS_ARR_ROWS  16   systolic array rows (sub-matrix height)
// SYS_ARR_COLS  16   systolic array cols (number of banks)
// derived: NUM_SUBMATS_M=MAX_OUT_ROWS/SYS_ARR_ROWS (8), NUM_SUBMATS_N=MAX_OUT_COLS/SYS_ARR_COLS (8)
// derived: NUM_ACCUM_ROWS=MAX_OUT_ROWS*NUM_SUBMATS_N (1024), ADDR_WIDTH=$clog2(NUM_ACCUM_ROWS) (10)
// PORTS
// clk          in   1                          single clock, rising edge
// reset        in   1                          synchronous, active-high
// wr_en_in     in   1                          write request for the row entering column 0
// wr_sub_row   in   $clog2(SYS_ARR_ROWS)       row within the sub-matrix being written
// wr_submat_m  in   $clog2(NUM_SUBMATS_M)      sub-matrix row index (write)
// wr_submat_n  in   $clog2(NUM_SUBMATS_N)      sub-matrix col index (write)
// wr_data      in   DATA_WIDTH*SYS_ARR_COLS    column c at [c*DATA_WIDTH +: DATA_WIDTH], pre-skewed by the array
// wr_en_out    out  SYS_ARR_COLS               per-bank write enables, skewed (observability)
// rd_en        in   SYS_ARR_COLS               per-bank read enables
// rd_sub_row   in   $clog2(SYS_ARR_ROWS)       row within the sub-matrix being read
// rd_submat_m  in   $clog2(NUM_SUBMATS_M)      sub-matrix row index (read)
// rd_submat_n  in   $clog2(NUM_SUBMATS_N)      sub-matrix col index (read)
// rd_data      out  DATA_WIDTH*SYS_ARR_COLS    registered read row, same packing as wr_data
// BEHAVIOUR
// - Address map, shared by read and write: addr = (submat_m*SYS_ARR_ROWS + sub_row)*NUM_SUBMATS_N + submat_n, width ADDR_WIDTH.
// - Write controller: per-column shift pipeline of {en, addr}.
//   - Bank c sees wr_en_in and the address computed from the wr_* inputs delayed c+1 cycles.
//   - wr_en_out[c] is the delayed enable.
// - Read controller: combinational. All banks receive the same address, computed from the rd_* inputs, with no skew.
// - Bank c write: when its enable is high, mem_c[addr] <= mem_c[addr] + wr_data[c].
//   - The sum is truncated modulo 2^DATA_WIDTH; there is no saturation.
//   - Bank c uses the wr_data slice present on the cycle its delayed enable is high.
// - Bank c read: when rd_en[c] is high, rd_data[c] <= mem_c[rd_addr] on the next edge (1-cycle latency).
//   - When rd_en[c] is low, rd_data[c] holds its previous value.
// - Same-bank read and write to the same address in one cycle: the read returns the pre-write value.
// - Every write accumulates. Repeated writes to one location sum, which implements K-dimension tiling.
// - reset, applied on a clock edge:
//   - all memory entries = 0; rd_data = 0;
//   - write pipeline cleared so wr_en_out = 0;
//   - any in-flight skewed writes are dropped.
// - Reset has priority over read and write in the same cycle.
// - Indices are in range by construction: no bounds checking. Address arithmetic wraps at ADDR_WIDTH.
// TESTING
// - Reset: pulse reset, then read (m=0,n=0) rows 0..15 with rd_en=16'hFFFF -> every rd_data is 0.
// - Write skew: wr_en_in=1 for 1 cycle at (m=2,n=3,row=5) -> wr_en_out[c] is high exactly at cycle c+1; every bank writes addr 299.
// - Single write pass: rows 0..15 at (0,0), each column = sub_row+1, then read rows 0..15 -> each column = sub_row+1, 1 cycle after rd_en.
// - Accumulate: the same pass repeated twice -> reads return 2*(sub_row+1).
//   - Values 200+100 in one location -> 44 (mod 256 wrap).
// - Isolation: write (0,0) and (2,3) with different data -> each sub-matrix reads back only its own data.
//   - rd_en=0 holds rd_data.
// - Reset mid-operation: reset asserted while skewed writes are in flight -> pending writes are dropped and the table reads all zero afterwards.

Source files
------------

// File: rtl/accum_table_system.sv
// Banked accumulator table: per-column skewed read-modify-write, one full-row read per access.
// Write lands c+1 cycles after request on bank c; read data is registered (1 cycle); no backpressure.
module accum_table_system #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    localparam int NUM_SUBMATS_M  = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_SUBMATS_N,
    localparam int ADDR_WIDTH     = $clog2(NUM_ACCUM_ROWS),
    localparam int ROW_W          = $clog2(SYS_ARR_ROWS),
    localparam int M_W            = $clog2(NUM_SUBMATS_M),
    localparam int N_W            = $clog2(NUM_SUBMATS_N)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en_in,
    input  logic [ROW_W-1:0]                   wr_sub_row,
    input  logic [M_W-1:0]                     wr_submat_m,
    input  logic [N_W-1:0]                     wr_submat_n,
    input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] wr_data,
    output logic [SYS_ARR_COLS-1:0]            wr_en_out,
    input  logic [SYS_ARR_COLS-1:0]            rd_en,
    input  logic [ROW_W-1:0]                   rd_sub_row,
    input  logic [M_W-1:0]                     rd_submat_m,
    input  logic [N_W-1:0]                     rd_submat_n,
    output logic [DATA_WIDTH*SYS_ARR_COLS-1:0] rd_data
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic addr_t calc_addr(input logic [M_W-1:0] m,
                                        input logic [ROW_W-1:0] sub_row,
                                        input logic [N_W-1:0] n);
        calc_addr = (addr_t'(m) * addr_t'(SYS_ARR_ROWS) + addr_t'(sub_row))
                    * addr_t'(NUM_SUBMATS_N) + addr_t'(n);
    endfunction

    addr_t wr_addr;
    addr_t rd_addr;

    assign wr_addr = calc_addr(wr_submat_m, wr_sub_row, wr_submat_n);
    assign rd_addr = calc_addr(rd_submat_m, rd_sub_row, rd_submat_n);

    // Stage c of the shift pipeline drives bank c, matching the array's diagonal wavefront.
    logic [SYS_ARR_COLS-1:0] pipe_en_d, pipe_en_q;
    addr_t [SYS_ARR_COLS-1:0] pipe_addr_d, pipe_addr_q;

    always_comb begin
        pipe_en_d      = '0;
        pipe_addr_d    = '0;
        pipe_en_d[0]   = wr_en_in;
        pipe_addr_d[0] = wr_addr;
        for (int c = 1; c < SYS_ARR_COLS; c++) begin
            pipe_en_d[c]   = pipe_en_q[c-1];
            pipe_addr_d[c] = pipe_addr_q[c-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_en_q   <= '0;
            pipe_addr_q <= '0;
        end else begin
            pipe_en_q   <= pipe_en_d;
            pipe_addr_q <= pipe_addr_d;
        end
    end

    logic [DATA_WIDTH*SYS_ARR_COLS-1:0] rd_data_d, rd_data_q;

    for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_bank
        logic [NUM_ACCUM_ROWS-1:0][DATA_WIDTH-1:0] mem_q;
        logic [DATA_WIDTH-1:0] sum_d;
        logic [DATA_WIDTH-1:0] rd_word_d;

        // Read samples mem_q before this edge's write, so a colliding read sees the old value.
        always_comb begin
            sum_d     = mem_q[pipe_addr_q[c]] + wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            rd_word_d = rd_data_q[c*DATA_WIDTH +: DATA_WIDTH];
            if (rd_en[c]) begin
                rd_word_d = mem_q[rd_addr];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q <= '0;
            end else if (pipe_en_q[c]) begin
                mem_q[pipe_addr_q[c]] <= sum_d;
            end
        end

        assign rd_data_d[c*DATA_WIDTH +: DATA_WIDTH] = rd_word_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign wr_en_out = pipe_en_q;

endmodule

// File: tb/tb_accum_table_system.sv
// Randomized and directed bench for accum_table_system against a per-cycle table model.
module tb_accum_table_system;

    localparam int COLS   = 16;
    localparam int ROWS   = 16;
    localparam int NSN    = 8;
    localparam int NACC   = 1024;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en_in;
    logic [3:0]   wr_sub_row, rd_sub_row;
    logic [2:0]   wr_submat_m, wr_submat_n, rd_submat_m, rd_submat_n;
    logic [127:0] wr_data, rd_data;
    logic [15:0]  wr_en_out, rd_en;

    accum_table_system dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en_in   (wr_en_in),
        .wr_sub_row (wr_sub_row),
        .wr_submat_m(wr_submat_m),
        .wr_submat_n(wr_submat_n),
        .wr_data    (wr_data),
        .wr_en_out  (wr_en_out),
        .rd_en      (rd_en),
        .rd_sub_row (rd_sub_row),
        .rd_submat_m(rd_submat_m),
        .rd_submat_n(rd_submat_n),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Reference: table contents, request history by sample edge, last reset edge.
    logic [7:0]   mdl [COLS][NACC];
    logic         en_h [64];
    int           addr_h [64];
    int           cyc;
    int           last_rst;
    logic [127:0] exp_rd;
    logic [15:0]  exp_we;
    int           n_checks;
    int           n_errors;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int addr_of(input int m, input int row, input int n);
        return ((m * ROWS + row) * NSN + n) % NACC;
    endfunction

    // One clock edge: update the model from the inputs present at the edge, then compare.
    task automatic step();
        int s;
        @(posedge clk);
        cyc++;
        en_h[cyc % 64]   = wr_en_in;
        addr_h[cyc % 64] = addr_of(int'(wr_submat_m), int'(wr_sub_row), int'(wr_submat_n));
        if (reset) begin
            for (int c = 0; c < COLS; c++)
                for (int a = 0; a < NACC; a++)
                    mdl[c][a] = 8'h00;
            exp_rd   = '0;
            last_rst = cyc;
        end else begin
            for (int c = 0; c < COLS; c++)
                if (rd_en[c])
                    exp_rd[c*8 +: 8] = mdl[c][addr_of(int'(rd_submat_m), int'(rd_sub_row), int'(rd_submat_n))];
            for (int c = 0; c < COLS; c++) begin
                s = cyc - c - 1;
                if (s > last_rst && en_h[s % 64])
                    mdl[c][addr_h[s % 64]] = mdl[c][addr_h[s % 64]] + wr_data[c*8 +: 8];
            end
        end
        for (int c = 0; c < COLS; c++) begin
            s = cyc - c;
            exp_we[c] = (s > last_rst) && en_h[s % 64];
        end
        #1;
        check("rd_data", rd_data, exp_rd);
        check("wr_en_out", {112'd0, wr_en_out}, {112'd0, exp_we});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Issues nrows consecutive rows; lane c carries value for row r exactly c+1 cycles later.
    task automatic write_rows(input int m, input int n, input int row0, input int nrows,
                              input int base, input int mult, input int add);
        int r;
        for (int t = 0; t < nrows + COLS + 1; t++) begin
            wr_en_in    = (t < nrows);
            wr_submat_m = 3'(m);
            wr_submat_n = 3'(n);
            wr_sub_row  = 4'(row0 + t);
            for (int c = 0; c < COLS; c++) begin
                r = t - c - 1;
                if (r >= 0 && r < nrows)
                    wr_data[c*8 +: 8] = 8'(base + mult * (r + 1) + add * c);
                else
                    wr_data[c*8 +: 8] = 8'($urandom);
            end
            step();
        end
        wr_en_in = 1'b0;
    endtask

    task automatic read_rows(input int m, input int n, input logic [15:0] mask, input int exp_mult);
        rd_en       = mask;
        rd_submat_m = 3'(m);
        rd_submat_n = 3'(n);
        for (int r = 0; r < ROWS; r++) begin
            rd_sub_row = 4'(r);
            step();
            if (exp_mult >= 0)
                check("rd_row", rd_data, {16{8'(exp_mult * (r + 1))}});
        end
        rd_en = '0;
        step();
    endtask

    task automatic read_one(input int m, input int n, input int row);
        rd_en       = 16'hFFFF;
        rd_submat_m = 3'(m);
        rd_submat_n = 3'(n);
        rd_sub_row  = 4'(row);
        step();
        rd_en = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        last_rst = 0;
        exp_rd   = '0;
        for (int i = 0; i < 64; i++) begin
            en_h[i]   = 1'b0;
            addr_h[i] = 0;
        end
        reset = 1'b0; wr_en_in = 1'b0; wr_sub_row = '0; wr_submat_m = '0; wr_submat_n = '0;
        wr_data = '0; rd_en = '0; rd_sub_row = '0; rd_submat_m = '0; rd_submat_n = '0;
        #2;

        do_reset();
        read_rows(0, 0, 16'hFFFF, 0);

        // Single request at (2,3,5) -> address 299 on every bank
        write_rows(2, 3, 5, 1, 7, 0, 0);
        read_one(2, 3, 5);
        check("skew_addr299", rd_data, {16{8'd7}});

        write_rows(0, 0, 0, 16, 0, 1, 0);
        read_rows(0, 0, 16'hFFFF, 1);
        write_rows(0, 0, 0, 16, 0, 1, 0);
        read_rows(0, 0, 16'hFFFF, 2);

        write_rows(1, 1, 4, 1, 200, 0, 0);
        write_rows(1, 1, 4, 1, 100, 0, 0);
        read_one(1, 1, 4);
        check("wrap_300", rd_data, {16{8'd44}});

        write_rows(2, 3, 0, 16, 0, 3, 1);
        read_rows(0, 0, 16'hFFFF, 2);
        read_rows(2, 3, 16'hFFFF, -1);
        read_rows(2, 3, 16'h5A3C, -1);

        // Random traffic over a small window so reads and writes collide often
        for (int i = 0; i < 1500; i++) begin
            reset       = ($urandom_range(99) == 0);
            wr_en_in    = 1'($urandom_range(1));
            wr_submat_m = 3'($urandom_range(1));
            wr_submat_n = 3'($urandom_range(1));
            wr_sub_row  = 4'($urandom_range(3));
            wr_data     = {$urandom, $urandom, $urandom, $urandom};
            rd_en       = 16'($urandom);
            rd_submat_m = 3'($urandom_range(1));
            rd_submat_n = 3'($urandom_range(1));
            rd_sub_row  = 4'($urandom_range(3));
            step();
        end
        reset    = 1'b0;
        wr_en_in = 1'b0;
        rd_en    = '0;
        repeat (COLS + 2) step();

        // Reset while skewed writes are still in flight
        for (int t = 0; t < 8; t++) begin
            wr_en_in    = 1'b1;
            wr_submat_m = 3'd0;
            wr_submat_n = 3'd0;
            wr_sub_row  = 4'(t);
            wr_data     = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        reset = 1'b1;
        step();
        reset    = 1'b0;
        wr_en_in = 1'b0;
        repeat (COLS + 4) begin
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        read_rows(0, 0, 16'hFFFF, 0);
        read_rows(2, 3, 16'hFFFF, 0);
        read_rows(1, 1, 16'hFFFF, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
